// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : bit_serializer
// Brief    : Parallel-to-serial word shifter with a downstream hold/stall input.
//            Define BIT_SERIALIZER_LSB_FIRST_EN for LSB-first bit order
//            (MSB-first otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module bit_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              hold,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              bit_last,
    output logic [15:0]       frame_cnt
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] shreg_adv;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              at_last;
    logic              accept;

    assign at_last   = (cnt_q == CNT_LAST);
    assign s_ready   = rst_n && ((state_q == ST_IDLE) || (at_last && !hold));
    assign bit_valid = rst_n && (state_q == ST_SHIFT) && !hold;
    assign bit_last  = bit_valid && at_last;
    assign accept    = s_valid && s_ready;
    assign frame_cnt = frame_cnt_q;

`ifdef BIT_SERIALIZER_LSB_FIRST_EN
    assign bit_out   = shreg_q[0];
    assign shreg_adv = {1'b0, shreg_q[DATA_W-1:1]};
`else
    assign bit_out   = shreg_q[DATA_W-1];
    assign shreg_adv = {shreg_q[DATA_W-2:0], 1'b0};
`endif

    // A new word overrides the shift of the final bit, so back-to-back words
    // stream without a gap cycle.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        frame_cnt_d = frame_cnt_q + {15'd0, bit_last};
        if (accept) begin
            state_d = ST_SHIFT;
            shreg_d = s_data;
            cnt_d   = '0;
        end else if (bit_valid) begin
            shreg_d = shreg_adv;
            cnt_d   = cnt_q + 1'b1;
            if (at_last) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_bit_serializer
// Brief    : Self-checking bench for bit_serializer (DATA_W = 8), queue-based
//            reference model plus directed scenarios with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic [W-1:0] s_data  = '0;
    logic         s_valid = 1'b0;
    logic         hold    = 1'b0;
    wire          s_ready;
    wire          bit_out;
    wire          bit_valid;
    wire          bit_last;
    wire  [15:0]  frame_cnt;

    always #5 clk = ~clk;

    bit_serializer #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .hold      (hold),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .bit_last  (bit_last),
        .frame_cnt (frame_cnt)
    );

    int cmp_n  = 0;
    int fail_n = 0;

    // Reference model: queue of pending serial bits, each tagged with "last of word".
    bit          m_bit[$];
    bit          m_last[$];
    logic [15:0] m_frame  = '0;
    bit          m_init   = 1'b0;
    bit          force_on = 1'b0;

    int          neg_cnt = 0;
    int          acc     = 0;
    int          n_valid = 0;
    int          n_last  = 0;
    int          last_k  = 0;
    logic [31:0] obs     = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            fail_n++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic e_valid, e_ready, e_last, e_bit;
        neg_cnt++;
        if (force_on) m_frame = 16'hFFFF;
        e_valid = rst_n && (m_bit.size() > 0) && !hold;
        e_ready = rst_n && ((m_bit.size() == 0) || (m_bit.size() == 1 && !hold));
        e_bit   = (m_bit.size() > 0) ? m_bit[0] : 1'b0;
        e_last  = e_valid && m_last[0];
        if (m_init) begin
            check("s_ready", {31'd0, s_ready}, {31'd0, e_ready});
            check("bit_valid", {31'd0, bit_valid}, {31'd0, e_valid});
            check("bit_last", {31'd0, bit_last}, {31'd0, e_last});
            check("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_frame});
            if (e_valid) check("bit_out", {31'd0, bit_out}, {31'd0, e_bit});
        end
        if (bit_valid === 1'b1) begin
            obs = {obs[30:0], bit_out};
            n_valid++;
        end
        if (bit_last === 1'b1) begin
            n_last++;
            last_k = neg_cnt - acc;
        end
        if (!rst_n) begin
            m_bit.delete();
            m_last.delete();
            m_frame = '0;
            m_init  = 1'b1;
        end else begin
            if (e_valid) begin
                if (e_last) m_frame = m_frame + 16'd1;
                void'(m_bit.pop_front());
                void'(m_last.pop_front());
            end
            if (s_valid && e_ready) begin
                for (int i = 0; i < W; i++) begin
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
                    m_bit.push_back(s_data[i]);
`else
                    m_bit.push_back(s_data[W-1-i]);
`endif
                    m_last.push_back(i == W-1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        hold    = 1'b0;
        tick();
        @(negedge clk);
        check("rst_outputs", {29'd0, s_ready, bit_valid, bit_last}, 32'd0);
        check("rst_frame", {16'd0, frame_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [W-1:0] w);
        bit done;
        done    = 1'b0;
        s_data  = w;
        s_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            done = (s_ready === 1'b1);
            @(posedge clk);
            if (done) acc = neg_cnt;
            #1;
        end
        s_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_last(input int start, input string name);
        int i;
        i = 0;
        while (n_last == start && i < 60) begin
            tick();
            i++;
        end
        if (n_last == start) check(name, 32'd0, 32'd1);
    endtask

    initial begin
        int bv, bl, a1;
        logic       frz;
        logic [7:0] exp96, exp01;
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
        frz = 1'b1; exp96 = 8'h69; exp01 = 8'h80;
`else
        frz = 1'b0; exp96 = 8'h96; exp01 = 8'h01;
`endif
        // Single word from IDLE, accepted on the first edge after reset.
        do_reset();
        bv = n_valid; bl = n_last;
        send(8'hA5);
        wait_last(bl, "t1_timeout");
        check("t1_bits", {24'd0, obs[7:0]}, 32'hA5);
        check("t1_nvalid", n_valid - bv, 32'd8);
        check("t1_last_cycle", last_k, 32'd8);
        check("t1_frame", {16'd0, frame_cnt}, 32'd1);
        @(negedge clk);
        check("t1_idle", {30'd0, s_ready, bit_valid}, 32'd2);
        tick();

        // Back-to-back words with s_valid held.
        do_reset();
        bv = n_valid; bl = n_last;
        send(8'hA5);
        a1 = acc;
        send(8'h3C);
        check("t2_gap", acc - a1, 32'd8);
        wait_last(bl + 1, "t2_timeout");
        check("t2_bits", {16'd0, obs[15:0]}, 32'hA53C);
        check("t2_nvalid", n_valid - bv, 32'd16);
        check("t2_nlast", n_last - bl, 32'd2);
        check("t2_frame", {16'd0, frame_cnt}, 32'd2);

        // Three-cycle hold after the second bit has been shown.
        do_reset();
        bl = n_last;
        send(8'h96);
        tick();
        tick();
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t3_hold_bit", {31'd0, bit_out}, {31'd0, frz});
            check("t3_hold_valid", {31'd0, bit_valid}, 32'd0);
            tick();
        end
        hold = 1'b0;
        wait_last(bl, "t3_timeout");
        check("t3_bits", {24'd0, obs[7:0]}, {24'd0, exp96});
        check("t3_last_cycle", last_k, 32'd11);
        check("t3_frame", {16'd0, frame_cnt}, 32'd1);

        // Reset during bit 5 discards the word; next word is clean.
        do_reset();
        bl = n_last;
        send(8'hA5);
        for (int k = 0; k < 4; k++) tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("t4_rst_outs", {29'd0, s_ready, bit_valid, bit_last}, 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t4_after_ready", {30'd0, s_ready, bit_valid}, 32'd2);
        check("t4_after_frame", {16'd0, frame_cnt}, 32'd0);
        tick();
        check("t4_no_last", n_last - bl, 32'd0);
        send(8'hFF);
        wait_last(bl, "t4_timeout");
        check("t4_bits", {24'd0, obs[7:0]}, 32'hFF);
        check("t4_frame", {16'd0, frame_cnt}, 32'd1);

        // frame_cnt wraps from 0xFFFF to 0x0000.
        tick();
        force_on = 1'b1;
        force dut.frame_cnt_q = 16'hFFFF;
        tick();
        tick();
        release dut.frame_cnt_q;
        force_on = 1'b0;
        @(negedge clk);
        check("t5_preload", {16'd0, frame_cnt}, 32'hFFFF);
        tick();
        bl = n_last;
        send(8'h01);
        wait_last(bl, "t5_timeout");
        check("t5_bits", {24'd0, obs[7:0]}, {24'd0, exp01});
        check("t5_wrap", {16'd0, frame_cnt}, 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", cmp_n, fail_n);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
